// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Single-port byte-wide RAM controller arbitrating between the
//             instruction-fetch path and the MEM stage. Splits 1/2/4-byte
//             accesses into byte transfers and assembles little-endian words.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch side
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  mem_take_if,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  // MEM stage side
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_size,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  mem_busy,
  // external byte RAM
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_RD  = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_t;

  localparam logic [2:0] C_WORD_BYTES = 3'd4;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [2:0]            r_n;
  logic [2:0]            r_cnt;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [31:0]           r_if_inst;
  logic [31:0]           r_mem_rdata;
  logic                  r_if_done;
  logic                  r_mem_done;

  logic                  w_accept_mem;
  logic                  w_accept_if;
  logic                  w_is_rd;
  logic                  w_flush_abort;
  logic                  w_capture;
  logic                  w_last_cap;
  logic                  w_addr_phase;
  logic                  w_wr_last;
  logic [1:0]            w_rd_idx;
  logic [2:0]            w_mem_n;
  logic [31:0]           w_assembled;

  // Byte count of a MEM-stage access: sizes 2 and 3 both mean a full word
  always_comb begin
    case (mem_size)
      2'd0:    w_mem_n = 3'd1;
      2'd1:    w_mem_n = 3'd2;
      default: w_mem_n = C_WORD_BYTES;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and acceptance decode; MEM stage wins over fetch
  always_comb begin
    w_next       = r_state;
    w_accept_mem = 1'b0;
    w_accept_if  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_accept_mem = 1'b1;
          w_next       = mem_we ? S_MEM_WR : S_MEM_RD;
        end else if (if_req) begin
          w_accept_if = 1'b1;
          w_next      = S_IF_RD;
        end
      end
      S_IF_RD: begin
        // r_cnt == N+1 is the done cycle of a read
        if (if_flush || (r_cnt == r_n + 3'd1)) w_next = S_IDLE;
      end
      S_MEM_RD: begin
        if (r_cnt == r_n + 3'd1) w_next = S_IDLE;
      end
      S_MEM_WR: begin
        // r_cnt == N is the done cycle of a write
        if (r_cnt == r_n) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read datapath: byte addressed at r_cnt == i arrives one cycle later,
  // so r_cnt values 1..N carry bytes 0..N-1 on ram_din
  assign w_is_rd       = (r_state == S_IF_RD) || (r_state == S_MEM_RD);
  assign w_flush_abort = (r_state == S_IF_RD) && if_flush;
  assign w_capture     = w_is_rd && !w_flush_abort && (r_cnt != 3'd0) && (r_cnt <= r_n);
  assign w_last_cap    = w_capture && (r_cnt == r_n);
  assign w_rd_idx      = r_cnt[1:0] - 2'd1;
  assign w_addr_phase  = (r_state != S_IDLE) && (r_cnt < r_n);
  assign w_wr_last     = (r_state == S_MEM_WR) && (r_cnt == r_n - 3'd1);

  // Merge the incoming byte into the partially assembled word
  always_comb begin
    w_assembled                          = r_buf;
    w_assembled[{w_rd_idx, 3'b000} +: 8] = ram_din;
  end

  // Transfer bookkeeping, byte assembly and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_n         <= 3'd0;
      r_cnt       <= 3'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_if_inst   <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;

      if (w_accept_mem) begin
        r_base  <= mem_addr;
        r_n     <= w_mem_n;
        r_wdata <= mem_wdata;
        r_buf   <= 32'd0;
        r_cnt   <= 3'd0;
      end else if (w_accept_if) begin
        r_base <= if_addr;
        r_n    <= C_WORD_BYTES;
        r_buf  <= 32'd0;
        r_cnt  <= 3'd0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 3'd1;
      end

      if (w_capture) r_buf <= w_assembled;

      // Result and pulse land together in the cycle after the last byte
      if (w_last_cap) begin
        if (r_state == S_IF_RD) begin
          r_if_inst <= w_assembled;
          r_if_done <= 1'b1;
        end else begin
          r_mem_rdata <= w_assembled;
          r_mem_done  <= 1'b1;
        end
      end

      if (w_wr_last) r_mem_done <= 1'b1;
    end
  end

  assign mem_take_if = w_accept_if && !rst;
  assign mem_busy    = (r_state != S_IDLE);
  assign if_done     = r_if_done;
  assign if_inst     = r_if_inst;
  assign mem_done    = r_mem_done;
  assign mem_rdata   = r_mem_rdata;
  assign ram_a       = w_addr_phase ? (r_base + ADDR_WIDTH'(r_cnt)) : '0;
  assign ram_wr      = (r_state == S_MEM_WR) && w_addr_phase;
  assign ram_dout    = ram_wr ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench for mem_ctrl with a byte RAM model and a
//             shadow memory used to predict load/fetch data and timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_take_if, if_done, mem_done, mem_busy, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_a;
  logic [7:0]  ram_din, ram_dout;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .mem_take_if(mem_take_if), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // cycle schedule for the recorder (-1 = never)
  int          s_clr_mem, s_clr_if, s_flush, s_rst, s_if2;
  logic [31:0] s_if2_addr;

  // per-cycle observations
  logic        ob_take [32];
  logic        ob_busy [32];
  logic        ob_wr   [32];
  logic        ob_ifd  [32];
  logic        ob_memd [32];
  logic [31:0] ob_a    [32];
  logic [7:0]  ob_dout [32];
  logic [31:0] ob_inst [32];
  logic [31:0] ob_rdata[32];

  logic [7:0]  ram     [0:4095];
  logic [7:0]  exp_mem [0:4095];
  logic        ram_live = 1'b0;
  logic [31:0] cur_inst, cur_rdata;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0:       return 8'h13;
      1, 2, 3: return 8'h00;
      'h100:   return 8'h78;
      'h101:   return 8'h56;
      'h102:   return 8'h34;
      'h103:   return 8'h12;
      'h301:   return 8'hF0;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // little-endian read of n bytes from the shadow memory, upper bytes zero
  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] idx;
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
      idx = a + 32'(i);
      w[8*i +: 8] = exp_mem[idx[11:0]];
    end
    return w;
  endfunction

  // byte RAM: address in cycle k gives data in cycle k+1
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      ram_din <= ram[ram_a[11:0]];
      if (ram_live && ram_wr === 1'b1) ram[ram_a[11:0]] = ram_dout;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic sched_clear();
    s_clr_mem = -1; s_clr_if = -1; s_flush = -1; s_rst = -1; s_if2 = -1;
    s_if2_addr = 32'd0;
  endtask

  // Runs n cycles from the current drive point (cycle 0), sampling mid-cycle;
  // returns at the drive point of cycle n.
  task automatic record(input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == s_clr_mem) mem_req = 1'b0;
        if (c == s_clr_if)  if_req  = 1'b0;
        if (c == s_if2) begin if_req = 1'b1; if_addr = s_if2_addr; end
        if_flush = (c == s_flush);
        rst      = (c == s_rst);
      end
      @(negedge clk);
      ob_take[c] = mem_take_if; ob_busy[c] = mem_busy; ob_wr[c] = ram_wr;
      ob_ifd[c]  = if_done;     ob_memd[c] = mem_done;  ob_a[c]  = ram_a;
      ob_dout[c] = ram_dout;    ob_inst[c] = if_inst;   ob_rdata[c] = mem_rdata;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = $urandom; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b1; mem_addr = $urandom; mem_size = 2'd2;
    mem_wdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (mem_take_if !== 1'b0) begin bad++; $display("FAIL reset_take: got %b want 0", mem_take_if); end
    total++; if ({if_done, mem_done, mem_busy, ram_wr} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {if_done, mem_done, mem_busy, ram_wr}); end
    total++; if (ram_a !== 32'd0) begin bad++; $display("FAIL reset_ram_a: got %h want 0", ram_a); end
    total++; if (ram_dout !== 8'd0) begin bad++; $display("FAIL reset_ram_dout: got %h want 0", ram_dout); end
    total++; if (if_inst !== 32'd0) begin bad++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
    total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL reset_mem_rdata: got %h want 0", mem_rdata); end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    total++; if ({mem_busy, ram_wr, mem_take_if} !== 3'b0 || ram_a !== 32'd0) begin bad++; $display("FAIL idle_after_reset: busy/wr/take %b ram_a %h want 0", {mem_busy, ram_wr, mem_take_if}, ram_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    logic [4:0]  exp_ctl, got_ctl;
    logic [31:0] exp_a;
    sched_clear(); s_clr_if = 1;
    if_req = 1'b1; if_addr = 32'h0; mem_req = 1'b0;
    record(8);
    for (int c = 0; c < 8; c++) begin
      exp_ctl = {c == 0, (c >= 1 && c <= 6), 1'b0, c == 6, 1'b0};
      got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
      total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL fetch_ctl c%0d: got %b want %b (take,busy,wr,ifd,memd)", c, got_ctl, exp_ctl); end
      exp_a = (c >= 1 && c <= 4) ? 32'(c - 1) : 32'd0;
      total++; if (ob_a[c] !== exp_a) begin bad++; $display("FAIL fetch_ram_a c%0d: got %h want %h", c, ob_a[c], exp_a); end
    end
    total++; if (ob_inst[6] !== 32'h00000013) begin bad++; $display("FAIL fetch_inst: got %h want 00000013", ob_inst[6]); end
    cur_inst = 32'h00000013;
  endtask

  task automatic test_priority();
    logic [4:0]  exp_ctl, got_ctl;
    logic [31:0] exp_a, wexp;
    sched_clear(); s_clr_mem = 1; s_clr_if = 8;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h100; mem_wdata = $urandom;
    if_req = 1'b1; if_addr = 32'h40;
    wexp = model_read(32'h40, 4);
    record(15);
    for (int c = 0; c < 15; c++) begin
      exp_ctl = {c == 7, (c >= 1 && c <= 6) || (c >= 8 && c <= 13), 1'b0, c == 13, c == 6};
      got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
      total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL prio_ctl c%0d: got %b want %b (take,busy,wr,ifd,memd)", c, got_ctl, exp_ctl); end
      if (c >= 1 && c <= 4)       exp_a = 32'h100 + 32'(c - 1);
      else if (c >= 8 && c <= 11) exp_a = 32'h40 + 32'(c - 8);
      else                        exp_a = 32'd0;
      total++; if (ob_a[c] !== exp_a) begin bad++; $display("FAIL prio_ram_a c%0d: got %h want %h", c, ob_a[c], exp_a); end
    end
    total++; if (ob_rdata[6] !== 32'h12345678) begin bad++; $display("FAIL prio_rdata: got %h want 12345678", ob_rdata[6]); end
    total++; if (ob_inst[6] !== cur_inst) begin bad++; $display("FAIL prio_inst_hold: got %h want %h", ob_inst[6], cur_inst); end
    total++; if (ob_inst[13] !== wexp) begin bad++; $display("FAIL prio_inst: got %h want %h", ob_inst[13], wexp); end
    cur_inst = wexp; cur_rdata = 32'h12345678;
  endtask

  task automatic test_store_half();
    logic [4:0]  exp_ctl, got_ctl;
    logic [31:0] exp_a;
    logic [7:0]  exp_d;
    sched_clear(); s_clr_mem = 1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'h200; mem_wdata = 32'hAABBCCDD;
    record(5);
    for (int c = 0; c < 5; c++) begin
      exp_ctl = {1'b0, (c >= 1 && c <= 3), (c >= 1 && c <= 2), 1'b0, c == 3};
      got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
      total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL sth_ctl c%0d: got %b want %b (take,busy,wr,ifd,memd)", c, got_ctl, exp_ctl); end
      exp_a = (c == 1) ? 32'h200 : (c == 2) ? 32'h201 : 32'd0;
      exp_d = (c == 1) ? 8'hDD : (c == 2) ? 8'hCC : 8'h00;
      total++; if (ob_a[c] !== exp_a || ob_dout[c] !== exp_d) begin bad++; $display("FAIL sth_bus c%0d: got a=%h d=%h want a=%h d=%h", c, ob_a[c], ob_dout[c], exp_a, exp_d); end
    end
    total++; if (ram[12'h200] !== 8'hDD || ram[12'h201] !== 8'hCC || ram[12'h202] !== exp_mem[12'h202]) begin bad++; $display("FAIL sth_ram: got %h %h %h want DD CC %h", ram[12'h200], ram[12'h201], ram[12'h202], exp_mem[12'h202]); end
    exp_mem[12'h200] = 8'hDD; exp_mem[12'h201] = 8'hCC;
  endtask

  task automatic test_load_byte();
    logic [4:0]  exp_ctl, got_ctl;
    logic [31:0] exp_a;
    sched_clear(); s_clr_mem = 1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h301; mem_wdata = $urandom;
    record(5);
    for (int c = 0; c < 5; c++) begin
      exp_ctl = {1'b0, (c >= 1 && c <= 3), 1'b0, 1'b0, c == 3};
      got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
      total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL ldb_ctl c%0d: got %b want %b (take,busy,wr,ifd,memd)", c, got_ctl, exp_ctl); end
      exp_a = (c == 1) ? 32'h301 : 32'd0;
      total++; if (ob_a[c] !== exp_a) begin bad++; $display("FAIL ldb_ram_a c%0d: got %h want %h", c, ob_a[c], exp_a); end
    end
    total++; if (ob_rdata[3] !== 32'h000000F0) begin bad++; $display("FAIL ldb_rdata: got %h want 000000f0", ob_rdata[3]); end
    cur_rdata = 32'h000000F0;
  endtask

  task automatic test_flush();
    logic [4:0]  exp_ctl, got_ctl;
    logic [31:0] exp_a, exp_i, w80;
    sched_clear(); s_flush = 3; s_if2 = 4; s_if2_addr = 32'h80; s_clr_if = 5;
    mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    w80 = model_read(32'h80, 4);
    record(12);
    for (int c = 0; c < 12; c++) begin
      exp_ctl = {c == 0 || c == 4, (c >= 1 && c <= 3) || (c >= 5 && c <= 10), 1'b0, c == 10, 1'b0};
      got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
      total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL flush_ctl c%0d: got %b want %b (take,busy,wr,ifd,memd)", c, got_ctl, exp_ctl); end
      if (c >= 1 && c <= 3)      exp_a = 32'h40 + 32'(c - 1);
      else if (c >= 5 && c <= 8) exp_a = 32'h80 + 32'(c - 5);
      else                       exp_a = 32'd0;
      total++; if (ob_a[c] !== exp_a) begin bad++; $display("FAIL flush_ram_a c%0d: got %h want %h", c, ob_a[c], exp_a); end
      exp_i = (c >= 10) ? w80 : cur_inst;
      total++; if (ob_inst[c] !== exp_i) begin bad++; $display("FAIL flush_inst c%0d: got %h want %h", c, ob_inst[c], exp_i); end
    end
    cur_inst = w80;
  endtask

  task automatic test_reset_midstore();
    logic [4:0]  exp_ctl, got_ctl;
    logic [31:0] exp_a, wd;
    logic [7:0]  exp_d;
    wd = $urandom;
    sched_clear(); s_clr_mem = 1; s_rst = 2;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd3; mem_addr = 32'h400; mem_wdata = wd;
    record(6);
    for (int c = 0; c < 6; c++) begin
      exp_ctl = {1'b0, (c >= 1 && c <= 2), (c >= 1 && c <= 2), 1'b0, 1'b0};
      got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
      total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL rstw_ctl c%0d: got %b want %b (take,busy,wr,ifd,memd)", c, got_ctl, exp_ctl); end
      exp_a = (c == 1) ? 32'h400 : (c == 2) ? 32'h401 : 32'd0;
      exp_d = (c == 1) ? wd[7:0] : (c == 2) ? wd[15:8] : 8'h00;
      total++; if (ob_a[c] !== exp_a || ob_dout[c] !== exp_d) begin bad++; $display("FAIL rstw_bus c%0d: got a=%h d=%h want a=%h d=%h", c, ob_a[c], ob_dout[c], exp_a, exp_d); end
      if (c >= 3) begin
        total++; if (ob_inst[c] !== 32'd0 || ob_rdata[c] !== 32'd0) begin bad++; $display("FAIL rstw_data c%0d: got inst=%h rdata=%h want 0 0", c, ob_inst[c], ob_rdata[c]); end
      end
    end
    total++; if (ram[12'h400] !== wd[7:0] || ram[12'h401] !== wd[15:8] || ram[12'h402] !== exp_mem[12'h402] || ram[12'h403] !== exp_mem[12'h403]) begin
      bad++; $display("FAIL rstw_ram: got %h %h %h %h want %h %h %h %h", ram[12'h400], ram[12'h401], ram[12'h402], ram[12'h403], wd[7:0], wd[15:8], exp_mem[12'h402], exp_mem[12'h403]);
    end
    exp_mem[12'h400] = wd[7:0]; exp_mem[12'h401] = wd[15:8];
    cur_inst = 32'd0; cur_rdata = 32'd0;
  endtask

  // Random fetches/loads/stores issued back to back (next request in the
  // cycle after completion), with occasional fetch flushes and address wrap.
  task automatic test_random();
    int          kind, sz, n, f, d, last, len;
    logic [31:0] addr, wd, word, exp_a, idx, exp_i;
    logic [7:0]  exp_d;
    logic [4:0]  exp_ctl, got_ctl;
    logic        in_x;
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 2));
      sz   = int'($urandom_range(0, 3));
      n    = (kind == 0 || sz >= 2) ? 4 : sz + 1;
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                         : 32'h0000_0500 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      f    = -1;
      if (kind == 0 && $urandom_range(0, 3) == 0) f = int'($urandom_range(1, 5));
      d    = (kind == 2) ? n + 1 : n + 2;
      last = (f >= 0) ? f : d;
      len  = last + 1;
      word = model_read(addr, n);
      sched_clear(); s_clr_mem = 1; s_clr_if = 1; s_flush = f;
      if (kind == 0) begin
        if_req = 1'b1; if_addr = addr;
      end else begin
        mem_req = 1'b1; mem_we = (kind == 2); mem_addr = addr;
        mem_size = 2'(sz); mem_wdata = wd;
      end
      record(len);
      for (int c = 0; c < len; c++) begin
        in_x    = (c >= 1) && (c <= n) && (c <= last);
        exp_ctl = {kind == 0 && c == 0, c >= 1 && c <= last, kind == 2 && in_x,
                   kind == 0 && f < 0 && c == d, kind != 0 && c == d};
        got_ctl = {ob_take[c], ob_busy[c], ob_wr[c], ob_ifd[c], ob_memd[c]};
        total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL rnd_ctl t%0d k%0d c%0d: got %b want %b (take,busy,wr,ifd,memd)", t, kind, c, got_ctl, exp_ctl); end
        exp_a = in_x ? addr + 32'(c - 1) : 32'd0;
        exp_d = 8'h00;
        if (kind == 2 && in_x) exp_d = wd[8*(c-1) +: 8];
        total++; if (ob_a[c] !== exp_a || ob_dout[c] !== exp_d) begin bad++; $display("FAIL rnd_bus t%0d c%0d: got a=%h d=%h want a=%h d=%h", t, c, ob_a[c], ob_dout[c], exp_a, exp_d); end
      end
      if (kind == 0) begin
        exp_i = (f < 0) ? word : cur_inst;
        total++; if (ob_inst[len-1] !== exp_i) begin bad++; $display("FAIL rnd_inst t%0d flush=%0d: got %h want %h", t, f, ob_inst[len-1], exp_i); end
        cur_inst = exp_i;
      end else if (kind == 1) begin
        total++; if (ob_rdata[d] !== word) begin bad++; $display("FAIL rnd_rdata t%0d n%0d: got %h want %h", t, n, ob_rdata[d], word); end
        total++; if (ob_inst[d] !== cur_inst) begin bad++; $display("FAIL rnd_inst_hold t%0d: got %h want %h", t, ob_inst[d], cur_inst); end
        cur_rdata = word;
      end else begin
        for (int i = 0; i < n; i++) begin
          idx = addr + 32'(i);
          exp_mem[idx[11:0]] = wd[8*i +: 8];
        end
      end
      if ($urandom_range(0, 2) == 0) repeat (int'($urandom_range(1, 2))) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_byte(i);
    cur_inst = 32'd0; cur_rdata = 32'd0;
    sched_clear();
    test_reset();
    ram_live = 1'b1;
    test_fetch();
    test_priority();
    test_store_half();
    test_load_byte();
    test_flush();
    test_reset_midstore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
